// File: rtl/acc_normalize.sv
// acc_normalize
//   Turns an aligned, accumulated fixed-point dot-product sum back into
//   sign / biased exponent / truncated mantissa floating point. Sits at the
//   PE output and feeds result writeback.
//
//   Input value  = acc_sum * 2^(acc_exp - FRAC_BITS), acc_sum two's complement.
//   Output value = (-1)^sign * 1.man * 2^(exp - bias), same bias as acc_exp.
//
//   Pipeline: S1 registers sign / magnitude / leading-zero count / exponent,
//   S2 registers the normalized, range-checked result. Valid/ready at both ends.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   input handshake
//   acc_sum, acc_exp      signed sum and its shared biased exponent
//   out_valid / out_ready output handshake
//   out_sign/exp/man      result fields (hidden 1 not stored)
//   out_zero/ovf/unf      exact zero / saturated to max finite / flushed to zero
module acc_normalize #(
    parameter int ACC_WIDTH     = 16,
    parameter int ACC_EXP_WIDTH = 6,
    parameter int FRAC_BITS     = 8,
    parameter int OUT_EXP_WIDTH = 5,
    parameter int OUT_MAN_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ACC_WIDTH-1:0]     acc_sum,
    input  logic [ACC_EXP_WIDTH-1:0] acc_exp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sign,
    output logic [OUT_EXP_WIDTH-1:0] out_exp,
    output logic [OUT_MAN_WIDTH-1:0] out_man,
    output logic                     out_zero,
    output logic                     out_ovf,
    output logic                     out_unf
);

    localparam int LZ_W = $clog2(ACC_WIDTH);
    // Two extra bits so the adjusted exponent can go negative or exceed the
    // input exponent range without wrapping.
    localparam int E_W  = ACC_EXP_WIDTH + 2;

    localparam logic signed [E_W-1:0] EXP_ADJ = E_W'(ACC_WIDTH - 1 - FRAC_BITS);
    localparam logic signed [E_W-1:0] EXP_MAX = E_W'((1 << OUT_EXP_WIDTH) - 2);
    localparam logic signed [E_W-1:0] EXP_ONE = E_W'(1);

    // ---------------- handshake ----------------
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s1_advance, in_fire;

    // S1 moves into S2 whenever S2 is empty or is being drained this cycle.
    assign s1_advance = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready   = ~s1_valid_q | s1_advance;
    assign in_fire    = in_valid & in_ready;

    // ---------------- S1: magnitude and leading zeros ----------------
    logic                     in_sign;
    logic [ACC_WIDTH-1:0]     in_mag;
    logic [LZ_W-1:0]          in_lz;

    logic                     s1_sign_q, s1_sign_d;
    logic [ACC_WIDTH-1:0]     s1_mag_q,  s1_mag_d;
    logic [LZ_W-1:0]          s1_lz_q,   s1_lz_d;
    logic                     s1_zero_q, s1_zero_d;
    logic [ACC_EXP_WIDTH-1:0] s1_exp_q,  s1_exp_d;

    always_comb begin
        in_sign = acc_sum[ACC_WIDTH-1];
        // Most negative input negates to itself, which read unsigned is the
        // correct magnitude 2^(ACC_WIDTH-1).
        in_mag  = in_sign ? -acc_sum : acc_sum;
        // Highest set bit wins; zero magnitude leaves the default.
        in_lz   = LZ_W'(ACC_WIDTH - 1);
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (in_mag[i]) in_lz = LZ_W'(ACC_WIDTH - 1 - i);
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s1_lz_d    = s1_lz_q;
        s1_zero_d  = s1_zero_q;
        s1_exp_d   = s1_exp_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_sign_d  = in_sign;
            s1_mag_d   = in_mag;
            s1_lz_d    = in_lz;
            s1_zero_d  = (in_mag == '0);
            s1_exp_d   = acc_exp;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // ---------------- S2: normalize, adjust exponent, range check ----------------
    logic [ACC_WIDTH-1:0]     s2_sh;
    logic signed [E_W-1:0]    s2_e;
    logic                     s2_sh_unused;

    logic                     out_sign_q, out_sign_d;
    logic [OUT_EXP_WIDTH-1:0] out_exp_q,  out_exp_d;
    logic [OUT_MAN_WIDTH-1:0] out_man_q,  out_man_d;
    logic                     out_zero_q, out_zero_d;
    logic                     out_ovf_q,  out_ovf_d;
    logic                     out_unf_q,  out_unf_d;

    assign s2_sh        = s1_mag_q << s1_lz_q;
    assign s2_e         = E_W'(s1_exp_q) + EXP_ADJ - E_W'(s1_lz_q);
    // Hidden bit and the truncated tail are intentionally dropped.
    assign s2_sh_unused = ^s2_sh;

    always_comb begin
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_man_d   = out_man_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        out_unf_d   = out_unf_q;
        if (s1_advance) begin
            out_valid_d = 1'b1;
            out_sign_d  = s1_sign_q;
            out_exp_d   = s2_e[OUT_EXP_WIDTH-1:0];
            out_man_d   = s2_sh[ACC_WIDTH-2 -: OUT_MAN_WIDTH];
            out_zero_d  = 1'b0;
            out_ovf_d   = 1'b0;
            out_unf_d   = 1'b0;
            if (s1_zero_q) begin
                out_sign_d = 1'b0;
                out_exp_d  = '0;
                out_man_d  = '0;
                out_zero_d = 1'b1;
            end else if (s2_e > EXP_MAX) begin
                out_exp_d  = EXP_MAX[OUT_EXP_WIDTH-1:0];
                out_man_d  = '1;
                out_ovf_d  = 1'b1;
            end else if (s2_e < EXP_ONE) begin
                out_sign_d = 1'b0;
                out_exp_d  = '0;
                out_man_d  = '0;
                out_unf_d  = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s1_lz_q     <= '0;
            s1_zero_q   <= 1'b0;
            s1_exp_q    <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_man_q   <= '0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s1_lz_q     <= s1_lz_d;
            s1_zero_q   <= s1_zero_d;
            s1_exp_q    <= s1_exp_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_man_q   <= out_man_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
            out_unf_q   <= out_unf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_man   = out_man_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_acc_normalize.sv
// Scoreboard bench for acc_normalize: directed corner beats, latency, stall,
// reset flush, then randomized traffic with random backpressure.
module tb_acc_normalize;
    localparam int AW  = 16;
    localparam int EW  = 6;
    localparam int FB  = 8;
    localparam int OEW = 5;
    localparam int OMW = 10;

    typedef logic [OMW+OEW+3:0] res_t; // {sign, exp, man, zero, ovf, unf}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] acc_sum = '0;
    logic [EW-1:0] acc_exp = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_sign;
    logic [OEW-1:0] out_exp;
    logic [OMW-1:0] out_man;
    logic          out_zero, out_ovf, out_unf;

    acc_normalize #(.ACC_WIDTH(AW), .ACC_EXP_WIDTH(EW), .FRAC_BITS(FB),
                    .OUT_EXP_WIDTH(OEW), .OUT_MAN_WIDTH(OMW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .acc_sum(acc_sum), .acc_exp(acc_exp), .out_valid(out_valid),
        .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
        .out_man(out_man), .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    res_t q[$];
    res_t out_res;
    assign out_res = {out_sign, out_exp, out_man, out_zero, out_ovf, out_unf};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: value = sum * 2^(exp-FB); normalize to 1.f * 2^k by finding
    // the power of two the magnitude lies in, truncate f to OMW bits.
    function automatic res_t model(input logic [AW-1:0] s, input logic [EW-1:0] x);
        int v, mag, k, e, man;
        logic sg;
        v   = $signed(s);
        sg  = (v < 0);
        mag = sg ? -v : v;
        if (mag == 0) return {1'b0, OEW'(0), OMW'(0), 3'b100};
        k = 0;
        while ((mag >> (k + 1)) != 0) k++;
        e   = int'(x) - FB + k;
        man = ((mag - (1 << k)) << OMW) >> k;
        if (e > (1 << OEW) - 2) return {sg, OEW'((1 << OEW) - 2), {OMW{1'b1}}, 3'b010};
        if (e < 1) return {1'b0, OEW'(0), OMW'(0), 3'b001};
        return {sg, OEW'(e), OMW'(man), 3'b000};
    endfunction

    // ---------------- monitor ----------------
    res_t prev_res;
    res_t exp_r;
    logic hold = 1'b0;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) chk("hold_stable", {out_valid, out_res}, {1'b1, prev_res});
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_beat", 32'(out_res), 32'hFFFF_FFFF);
                else begin
                    exp_r = q.pop_front();
                    chk("beat", 32'(out_res), 32'(exp_r));
                end
            end
            hold     = out_valid && !out_ready;
            prev_res = out_res;
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [AW-1:0] s, input logic [EW-1:0] x,
                         input logic ordy, input logic use_fix, input res_t fix,
                         output logic acc);
        @(negedge clk);
        in_valid  = v;
        acc_sum   = s;
        acc_exp   = x;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready && rst_n;
        if (acc) q.push_back(use_fix ? fix : model(s, x));
    endtask

    task automatic send_fix(input logic [AW-1:0] s, input logic [EW-1:0] x, input res_t r);
        logic a;
        int n = 0;
        do begin
            drive(1'b1, s, x, 1'b1, 1'b1, r, a);
            n++;
        end while (!a && n < 20);
        if (!a) chk("accept_timeout", 32'(a), 32'd1);
    endtask

    task automatic idle(input logic ordy);
        logic a;
        drive(1'b0, '0, '0, ordy, 1'b0, '0, a);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            idle(1'b1);
            n++;
        end
        repeat (2) idle(1'b1);
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic a;
        int   acc_cnt;
        logic [AW-1:0] sv[4];
        logic [AW-1:0] s;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_res),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // directed corner beats, back to back
        send_fix(16'h0100, 6'd15, {1'b0, 5'd15, 10'h000, 3'b000});
        send_fix(16'hFE80, 6'd15, {1'b1, 5'd15, 10'h200, 3'b000});
        send_fix(16'h8000, 6'd15, {1'b1, 5'd22, 10'h000, 3'b000});
        send_fix(16'h0000, 6'd20, {1'b0, 5'd0,  10'h000, 3'b100});
        send_fix(16'h7FFF, 6'd40, {1'b0, 5'd30, 10'h3FF, 3'b010});
        send_fix(16'h0001, 6'd0,  {1'b0, 5'd0,  10'h000, 3'b001});
        drain();

        // latency: two cycles from transfer to out_valid
        drive(1'b1, 16'h0300, 6'd10, 1'b1, 1'b0, '0, a);
        chk("lat_accept", 32'(a), 32'd1);
        idle(1'b1);
        chk("lat_cycle1", 32'(out_valid), 32'd0);
        idle(1'b1);
        chk("lat_cycle2", 32'(out_valid), 32'd1);
        drain();

        // stall: 4 beats offered with out_ready low, only 2 fit
        sv[0] = 16'h0123; sv[1] = 16'hF00D; sv[2] = 16'h4000; sv[3] = 16'hFFFF;
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sv[acc_cnt], 6'd18, 1'b0, 1'b0, '0, a);
            if (a) acc_cnt++;
        end
        chk("stall_accepted", 32'(acc_cnt), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        for (int n = 0; n < 20 && acc_cnt < 4; n++) begin
            drive(1'b1, sv[acc_cnt], 6'd18, 1'b1, 1'b0, '0, a);
            if (a) acc_cnt++;
        end
        chk("stall_all_in", 32'(acc_cnt), 32'd4);
        drain();

        // reset with both stages full
        drive(1'b1, 16'h0555, 6'd12, 1'b0, 1'b0, '0, a);
        drive(1'b1, 16'h0AAA, 6'd12, 1'b0, 1'b0, '0, a);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("pre_rst_full", {30'd0, out_valid, in_ready}, 32'b10);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data",  32'(out_res),   32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        drain();

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            s = AW'($urandom);
            case ($urandom_range(0, 3))
                0: s = s >> $urandom_range(0, AW - 1);
                1: s = -(s >> $urandom_range(0, AW - 1));
                default: ;
            endcase
            if ($urandom_range(0, 15) == 0) s = '0;
            drive($urandom_range(0, 9) < 7, s, EW'($urandom_range(0, 63)),
                  $urandom_range(0, 9) < 7, 1'b0, '0, a);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
